binary_to_ieee_seq: RTL and testbench
=====================================

// Module: binary_to_ieee_seq
// PURPOSE
//  Sequential fixed-point -> IEEE-754 single-precision encoder; inverse of the float->digit/fraction decoder.
//  Accepts sign + unsigned integer part + binary fraction part and normalises one bit per clock.
//  Emits a packed 32-bit float over a valid/ready handshake. Sits on the ALU result path toward float consumers.
// PARAMETERS
//  INT_W   5  width of integer part (in_digit)
//  FRAC_W  5  width of fraction part (in_float), LSB weight 2^-FRAC_W; constraint INT_W+FRAC_W-1 <= 23
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        input operand valid
//  in_ready   out  1        block can accept; high only in IDLE
//  in_sign    in   1        sign of operand (1 = negative)
//  in_digit   in   INT_W    unsigned integer part
//  in_float   in   FRAC_W   fraction bits, MSB = 2^-1
//  out_valid  out  1        out_data valid
//  out_ready  in   1        consumer accepts out_data
//  out_data   out  32       IEEE-754 single {sign, exp[7:0], mant[22:0]}
// BEHAVIOUR
//  - Reset (async, any state incl. mid-NORM): state=IDLE, out_valid=0, out_data=0, W=0, exp cnt=0; in-flight op dropped.
//  - N = INT_W+FRAC_W; W[N-1:0] working reg; E 8-bit exponent counter.
//  - IDLE: in_ready=1. Transfer = in_valid&&in_ready at rising edge:
//      W<={in_digit,in_float}; E<=127+INT_W-1; S<=in_sign.
//      If {in_digit,in_float}==0 -> DONE with out_data=32'h0000_0000 (-0 encodes as +0).
//      Else -> NORM.
//  - NORM: in_ready=0. Each cycle: if W[N-1]==1 -> out_data<={S,E,W[N-2:0],{(24-N){1'b0}}}, -> DONE;
//      else W<=W<<1, E<=E-1.
//  - DONE: out_valid=1; out_data held stable while out_ready=0. On out_ready -> IDLE (out_valid low next cycle).
//      No new input accepted in DONE; next accept earliest in the cycle after the handshake.
//  - Latency (accept edge to out_valid high): lz+1 cycles, lz = leading zeros of {digit,float};
//      range 1 (MSB set) .. N (only LSB set); zero operand: 1 cycle.
//  - Conversion exact: no rounding, no overflow/denormal possible for N<=24; E range 127-FRAC_W..127+INT_W-1.
//  - in_* sampled only at transfer edge; changes at other times ignored.
//  - out_data keeps last result after DONE->IDLE until next result is written (valid only with out_valid).
// STRUCTURE
//  - Shared include ieee754_defs.vh: EXP_BIAS=127, EXP_W=8, MANT_W=23, FP_W=32, state codes IDLE/NORM/DONE.
//  - Single module; 2-bit state reg, W shift reg, E down-counter, S flag, out_data reg.
//  - Optional sub-module ieee754_pack (combinational {S,E,mant} assembly), shared with future float blocks.
// TESTING
//  - sign=0 digit=5'b00101 float=5'b10000 (5.5) -> out_data=32'h40B0_0000, out_valid 3 cycles after accept.
//  - sign=1, same operand (-5.5) -> 32'hC0B0_0000, latency 3.
//  - digit=0 float=5'b00001 (2^-5) -> 32'h3D00_0000, latency 10; digit=31 float=31 -> 32'h41FF_C000, latency 1.
//  - digit=0 float=0 sign=1 -> 32'h0000_0000 after 1 cycle; in_ready low until handshake completes.
//  - out_ready held low 5 cycles in DONE -> out_valid/out_data stable, in_ready=0; in_valid pulses ignored.
//  - rst_n low mid-NORM (2 cycles after accepting 2^-5) -> out_valid=0, out_data=0, in_ready=1 after release;
//    next op 5.5 converts correctly to 32'h40B0_0000.

Source files
------------

// File: rtl/binary_to_ieee_seq_pkg.sv
// Shared IEEE-754 single-precision field widths and the encoder FSM state type.
package binary_to_ieee_seq_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int FP_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/binary_to_ieee_seq_pack.sv
// Combinational {sign, exponent, mantissa} assembly; the fraction below the
// hidden bit is left-aligned in the 23-bit mantissa field.
module binary_to_ieee_seq_pack
  import binary_to_ieee_seq_pkg::*;
#(
  parameter int N = 10
) (
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [N-2:0]     i_frac,
  output logic [FP_W-1:0]  o_word
);
  generate
    if (N - 1 == MANT_W) begin : g_full
      assign o_word = {i_sign, i_exp, i_frac};
    end else begin : g_pad
      assign o_word = {i_sign, i_exp, i_frac, {(MANT_W - N + 1){1'b0}}};
    end
  endgenerate
endmodule

// File: rtl/binary_to_ieee_seq.sv
// Sequential fixed-point to IEEE-754 single encoder: shifts the operand left one
// bit per clock until the hidden bit sits in the MSB, then packs the result.
module binary_to_ieee_seq
  import binary_to_ieee_seq_pkg::*;
#(
  parameter int INT_W  = 5,
  parameter int FRAC_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds data while valid is high and ready is low.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [INT_W-1:0]  in_digit,
  input  logic [FRAC_W-1:0] in_float,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   out_data,
  output logic [1:0]        dbg_state
);
  localparam int N = INT_W + FRAC_W;
  localparam logic [EXP_W-1:0] E_INIT = EXP_W'(EXP_BIAS + INT_W - 1);

  state_t             r_state;
  logic [N-1:0]       r_w;
  logic [EXP_W-1:0]   r_e;
  logic               r_s;
  logic [FP_W-1:0]    r_out_data;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [FP_W-1:0]    w_packed;

  binary_to_ieee_seq_pack #(.N(N)) u_pack (
    .i_sign (r_s),
    .i_exp  (r_e),
    .i_frac (r_w[N-2:0]),
    .o_word (w_packed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_w         <= '0;
      r_e         <= '0;
      r_s         <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_w        <= {in_digit, in_float};
            r_e        <= E_INIT;
            r_s        <= in_sign;
            r_in_ready <= 1'b0;
            r_state    <= ST_NORM;
          end
        end
        ST_NORM: begin
          // A zero operand finishes here too, so it costs one cycle and -0 becomes +0.
          if (r_w == '0) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_w[N-1]) begin
            r_out_data  <= w_packed;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_w <= r_w << 1;
            r_e <= r_e - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_binary_to_ieee_seq.sv
// Self-checking bench for binary_to_ieee_seq: arithmetic reference model,
// per-cycle compare against it, plus literal-expectation directed cases.
module tb_binary_to_ieee_seq;
  localparam int INT_W  = 5;
  localparam int FRAC_W = 5;
  localparam int N      = INT_W + FRAC_W;

  // clock / reset
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [INT_W-1:0]  in_digit = '0;
  logic [FRAC_W-1:0] in_float = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_data;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  binary_to_ieee_seq #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_digit  (in_digit),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value = digit + float/2^FRAC_W, written as 1.m * 2^(p-FRAC_W)
  function automatic logic [31:0] ref_word(input logic s, input int v);
    int p;
    int e;
    int m;
    logic [7:0]  e8;
    logic [22:0] m23;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < N; i++) if (v >= (1 << i)) p = i;
    e   = 127 + p - FRAC_W;
    m   = (v - (1 << p)) << (23 - p);
    e8  = e[7:0];
    m23 = m[22:0];
    return {s, e8, m23};
  endfunction

  function automatic int ref_lat(input int v);
    int p;
    if (v == 0) return 1;
    p = 0;
    for (int i = 0; i < N; i++) if (v >= (1 << i)) p = i;
    return (N - 1 - p) + 1;
  endfunction

  // Scoreboard: expected results queued on accept, popped when they should appear.
  logic [31:0] exp_q[$];
  bit          m_ready = 1'b1;
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_data  = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_cnt   = 0;
      m_data  = 32'h0;
      exp_q.delete();
    end else if (m_ready && in_valid) begin
      m_ready = 1'b0;
      m_cnt   = ref_lat(int'({in_digit, in_float}));
      exp_q.push_back(ref_word(in_sign, int'({in_digit, in_float})));
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        if (exp_q.size() > 0) m_data = exp_q.pop_front();
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check32("cyc_in_ready", {31'b0, in_ready}, {31'b0, m_ready});
      check32("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check32("cyc_out_data", out_data, m_data);
    end
  end

  // driver: one operation with literal expectations, holding out_ready low for hold cycles
  task automatic do_op(input logic s, input logic [INT_W-1:0] d, input logic [FRAC_W-1:0] f,
                       input logic [31:0] exp_word, input int exp_lat, input int hold, input string tag);
    int cnt;
    @(negedge clk);
    in_sign  = s;
    in_digit = d;
    in_float = f;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sign  = 1'($urandom_range(0, 1));
    in_digit = INT_W'($urandom_range(0, 31));
    in_float = FRAC_W'($urandom_range(0, 31));
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end while (!out_valid && cnt < 40);
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid never rose within %0d cycles", tag, cnt);
      return;
    end
    check32({tag, "_lat"}, cnt, exp_lat);
    check32({tag, "_data"}, out_data, exp_word);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check32({tag, "_hold_data"}, out_data, exp_word);
      check32({tag, "_hold_ready"}, {31'b0, in_ready}, 32'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check32({tag, "_post_valid"}, {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    int v;
    logic s;
    logic [INT_W-1:0]  d;
    logic [FRAC_W-1:0] f;
    repeat (3) @(negedge clk);
    check32("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check32("reset_out_data", out_data, 32'h0);
    check32("reset_in_ready", {31'b0, in_ready}, 32'h1);
    rst_n = 1'b1;

    do_op(1'b0, 5'b00101, 5'b10000, 32'h40B0_0000, 3, 0, "pos_5p5");
    do_op(1'b1, 5'b00101, 5'b10000, 32'hC0B0_0000, 3, 1, "neg_5p5");
    do_op(1'b0, 5'd0, 5'b00001, 32'h3D00_0000, 10, 0, "min_lsb");
    do_op(1'b0, 5'd31, 5'd31, 32'h41FF_C000, 1, 0, "max_all");
    do_op(1'b1, 5'd0, 5'd0, 32'h0000_0000, 1, 2, "neg_zero");
    do_op(1'b0, 5'd1, 5'd0, 32'h3F80_0000, 5, 5, "one_hold5");

    // async reset while normalising 2^-5
    @(negedge clk);
    in_digit = 5'd0;
    in_float = 5'b00001;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check32("midnorm_rst_valid", {31'b0, out_valid}, 32'h0);
    check32("midnorm_rst_data", out_data, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check32("midnorm_rel_ready", {31'b0, in_ready}, 32'h1);
    check32("midnorm_rel_valid", {31'b0, out_valid}, 32'h0);
    do_op(1'b0, 5'b00101, 5'b10000, 32'h40B0_0000, 3, 0, "after_rst");

    for (int k = 0; k < 60; k++) begin
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 7);
      else v = $urandom_range(0, (1 << N) - 1);
      {d, f} = N'(v);
      do_op(s, d, f, ref_word(s, v), ref_lat(v), $urandom_range(0, 3), "rand");
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
